// File: rtl/pipeline_stage_skid.sv
// pipeline_stage_skid
// Two-entry pipeline register with a skid buffer. The output register drives
// the downstream payload. The skid register catches one beat when downstream
// stalls. o_ready depends only on registered state, so the ready path is cut
// between the upstream and downstream sides.
// Optional build macro PIPELINE_STAGE_DEBUG_EN adds debug tick/ok sideband
// ports. These ports travel through both entries exactly like payload.
module pipeline_stage_skid #(
    parameter int unsigned         PC_WIDTH   = 32,
    parameter int unsigned         INST_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = PC_WIDTH'(-4)
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_flush,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [PC_WIDTH-1:0]   i_pc,
    input  logic [INST_WIDTH-1:0] i_inst,
    input  logic                  i_instCompressed,
`ifdef PIPELINE_STAGE_DEBUG_EN
    input  int                    i_dbgTick,
    input  logic                  i_dbgOk,
    output int                    o_dbgTick,
    output logic                  o_dbgOk,
`endif
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [PC_WIDTH-1:0]   o_pc,
    output logic [INST_WIDTH-1:0] o_inst,
    output logic                  o_instCompressed,
    output logic [1:0]            o_count
);

    logic                  outValid_q, outValid_d;
    logic                  skidValid_q, skidValid_d;
    logic [PC_WIDTH-1:0]   outPc_q, outPc_d;
    logic [INST_WIDTH-1:0] outInst_q, outInst_d;
    logic                  outComp_q, outComp_d;
    logic [PC_WIDTH-1:0]   skidPc_q, skidPc_d;
    logic [INST_WIDTH-1:0] skidInst_q, skidInst_d;
    logic                  skidComp_q, skidComp_d;
    logic [1:0]            count_q, count_d;
`ifdef PIPELINE_STAGE_DEBUG_EN
    int                    outTick_q, outTick_d;
    logic                  outOk_q, outOk_d;
    int                    skidTick_q, skidTick_d;
    logic                  skidOk_q, skidOk_d;
`endif

    logic upXfer;
    logic downXfer;

    assign o_ready  = ~skidValid_q;
    assign upXfer   = i_valid & o_ready;
    assign downXfer = outValid_q & i_ready;

    // Next-state selection.
    // A flush empties the stage and drops the incoming beat.
    // When the output register is free, it refills from skid first, then
    // from upstream. Otherwise an accepted beat parks in skid.
    always_comb begin
        outValid_d  = outValid_q;
        skidValid_d = skidValid_q;
        outPc_d     = outPc_q;
        outInst_d   = outInst_q;
        outComp_d   = outComp_q;
        skidPc_d    = skidPc_q;
        skidInst_d  = skidInst_q;
        skidComp_d  = skidComp_q;
`ifdef PIPELINE_STAGE_DEBUG_EN
        outTick_d   = outTick_q;
        outOk_d     = outOk_q;
        skidTick_d  = skidTick_q;
        skidOk_d    = skidOk_q;
`endif
        if (i_flush) begin
            outValid_d  = 1'b0;
            skidValid_d = 1'b0;
            outPc_d     = RESET_PC;
            outInst_d   = '0;
            outComp_d   = 1'b0;
`ifdef PIPELINE_STAGE_DEBUG_EN
            outOk_d     = 1'b0;
            skidOk_d    = 1'b0;
`endif
        end else if (!outValid_q || downXfer) begin
            if (skidValid_q) begin
                outValid_d  = 1'b1;
                skidValid_d = 1'b0;
                outPc_d     = skidPc_q;
                outInst_d   = skidInst_q;
                outComp_d   = skidComp_q;
`ifdef PIPELINE_STAGE_DEBUG_EN
                outTick_d   = skidTick_q;
                outOk_d     = skidOk_q;
`endif
            end else if (upXfer) begin
                outValid_d  = 1'b1;
                outPc_d     = i_pc;
                outInst_d   = i_inst;
                outComp_d   = i_instCompressed;
`ifdef PIPELINE_STAGE_DEBUG_EN
                outTick_d   = i_dbgTick;
                outOk_d     = i_dbgOk;
`endif
            end else begin
                outValid_d  = 1'b0;
            end
        end else if (upXfer) begin
            skidValid_d = 1'b1;
            skidPc_d    = i_pc;
            skidInst_d  = i_inst;
            skidComp_d  = i_instCompressed;
`ifdef PIPELINE_STAGE_DEBUG_EN
            skidTick_d  = i_dbgTick;
            skidOk_d    = i_dbgOk;
`endif
        end
        count_d = {1'b0, outValid_d} + {1'b0, skidValid_d};
    end

    // Control state and visible output payload, with synchronous reset.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            outValid_q  <= 1'b0;
            skidValid_q <= 1'b0;
            outPc_q     <= RESET_PC;
            outInst_q   <= '0;
            outComp_q   <= 1'b0;
            count_q     <= 2'd0;
`ifdef PIPELINE_STAGE_DEBUG_EN
            outOk_q     <= 1'b0;
            skidOk_q    <= 1'b0;
`endif
        end else begin
            outValid_q  <= outValid_d;
            skidValid_q <= skidValid_d;
            outPc_q     <= outPc_d;
            outInst_q   <= outInst_d;
            outComp_q   <= outComp_d;
            count_q     <= count_d;
`ifdef PIPELINE_STAGE_DEBUG_EN
            outOk_q     <= outOk_d;
            skidOk_q    <= skidOk_d;
`endif
        end
    end

    // Skid payload and debug tick need no reset because their valid bits guard them.
    always_ff @(posedge i_clock) begin
        skidPc_q   <= skidPc_d;
        skidInst_q <= skidInst_d;
        skidComp_q <= skidComp_d;
`ifdef PIPELINE_STAGE_DEBUG_EN
        outTick_q  <= outTick_d;
        skidTick_q <= skidTick_d;
`endif
    end

    assign o_valid          = outValid_q;
    assign o_pc             = outPc_q;
    assign o_inst           = outInst_q;
    assign o_instCompressed = outComp_q;
    assign o_count          = count_q;
`ifdef PIPELINE_STAGE_DEBUG_EN
    assign o_dbgTick        = outTick_q;
    assign o_dbgOk          = outOk_q;
`endif

endmodule

// File: doc/pipeline_stage_skid.md
PIPELINE_STAGE_SKID -- requirements
Module: pipeline_stage_skid

Interface
REQ-001 Parameter PC_WIDTH, 32, width of program-counter payload field.
REQ-002 Parameter INST_WIDTH, 32, width of instruction payload field.
REQ-003 Parameter RESET_PC, PC_WIDTH'(-4), value loaded into o_pc on reset and flush.
REQ-004 Port i_clock  in  1  clock; all state updates on rising edge.
REQ-005 Port i_reset  in  1  reset; synchronous, active-high.
REQ-006 Port i_flush  in  1  discard all held and incoming beats.
REQ-007 Port i_valid  in  1  upstream beat present.
REQ-008 Port o_ready  out  1  stage accepts upstream beat this cycle.
REQ-009 Port i_pc  in  PC_WIDTH  upstream program counter.
REQ-010 Port i_inst  in  INST_WIDTH  upstream instruction.
REQ-011 Port i_instCompressed  in  1  upstream compressed-instruction flag.
REQ-012 Port o_valid  out  1  downstream beat present.
REQ-013 Port i_ready  in  1  downstream accepts beat this cycle.
REQ-014 Port o_pc / o_inst / o_instCompressed  out  PC_WIDTH / INST_WIDTH / 1  downstream payload.
REQ-015 Port o_count  out  2  occupancy, 0..2.

Function
REQ-016 Storage SHALL be two entries: output register (drives o_*) and skid register; no combinational path from i_* payload to o_* payload.
REQ-017 o_ready SHALL equal NOT skid-occupied, driven only from state (no dependency on i_ready in the same cycle).
REQ-018 Upstream transfer SHALL occur when i_valid AND o_ready; downstream transfer when o_valid AND i_ready.
REQ-019 Output register empty or draining: load from skid if occupied, else from accepted upstream beat; else o_valid SHALL fall to 0.
REQ-020 Output register full and not draining: accepted upstream beat SHALL be written to skid.
REQ-021 Skid occupied and output draining: skid moves to output, skid emptied; o_ready SHALL be 0 that cycle so no beat is lost.
REQ-022 Beat order SHALL be preserved; latency input-to-output SHALL be 1 cycle when empty.
REQ-023 Payload outputs SHALL hold their previous value whenever the output register is not loaded.
REQ-024 o_count SHALL equal o_valid + skid-occupied, registered with state.
REQ-025 i_flush SHALL on the next edge clear o_valid and skid, set o_pc=RESET_PC, o_inst=0, o_instCompressed=0, o_count=0; upstream beat offered in the flush cycle SHALL be dropped.
REQ-026 i_reset SHALL take priority over i_flush; i_flush over all transfers.

Reset
REQ-027 After a reset edge: o_valid=0, skid empty, o_ready=1, o_count=0, o_pc=RESET_PC, o_inst=0, o_instCompressed=0.
REQ-028 Reset asserted mid-operation SHALL discard both entries within one edge, identical to REQ-027.

Configuration
REQ-029 Macro PIPELINE_STAGE_DEBUG_EN: when defined, add ports i_dbgTick (in, int), i_dbgOk (in, 1), o_dbgTick (out, int), o_dbgOk (out, 1) carried through both entries exactly as payload; o_dbgOk reset/flush to 0, o_dbgTick not reset.
REQ-030 Without PIPELINE_STAGE_DEBUG_EN those ports and their storage SHALL be absent; all other behaviour identical.

Verification
REQ-031 Reset then idle -> o_valid=0, o_ready=1, o_count=0, o_pc=32'hFFFF_FFFC, o_inst=0.
REQ-032 i_ready=1, stream pc 0,4,8 with i_valid=1 -> o_pc 0,4,8 one cycle later each, o_count stays 1, o_ready stays 1.
REQ-033 i_ready=0, send pc 0,4 -> o_pc=0, o_count=2, o_ready=0; beat pc 8 held on input not accepted; i_ready=1 -> outputs 0,4,8 in order, none lost or duplicated.
REQ-034 o_count=2, assert i_flush with i_valid=1 pc 12 -> next cycle o_valid=0, o_count=0, o_pc=RESET_PC; pc 12 never appears.
REQ-035 o_count=2, assert i_reset and i_flush together -> state matches REQ-031.
REQ-036 Randomised i_valid/i_ready 1000 cycles -> output sequence equals accepted input sequence, o_ready never 1 while o_count=2.
